// File: rtl/fifo_drain_pkg.sv
// Shared constants for the FIFO read-side drain controller.
package fifo_drain_pkg;

  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned FRAME_CNT_W = 16;
  localparam int unsigned IDX_W       = 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

endpackage

// File: rtl/fifo_drain_if.sv
// Valid/ready byte stream with a frame-end marker.
interface fifo_drain_if #(
  parameter int unsigned DATA_W = 8
) ();

  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_last;

  modport master (output m_valid, output m_data, output m_last, input m_ready);
  modport slave  (input m_valid, input m_data, input m_last, output m_ready);

endinterface

// File: rtl/drain_skid_buf.sv
// Two-entry output buffer; entry 0 is always the head so outputs come straight from flops.
module drain_skid_buf #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_data,
  output logic [1:0]       occupancy_c
);

  logic [WIDTH-1:0] data1;
  logic             valid1;
  logic             pop_c;

  assign pop_c       = pop_valid && pop_ready;
  assign occupancy_c = {1'b0, pop_valid} + {1'b0, valid1};

  // Shift-style update: a pop moves entry 1 into the head slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pop_valid <= 1'b0;
      valid1    <= 1'b0;
      pop_data  <= '0;
      data1     <= '0;
    end else begin
      case ({push, pop_c})
        2'b10: begin
          if (!pop_valid) begin
            pop_data  <= push_data;
            pop_valid <= 1'b1;
          end else begin
            data1  <= push_data;
            valid1 <= 1'b1;
          end
        end
        2'b01: begin
          pop_data  <= data1;
          pop_valid <= valid1;
          valid1    <= 1'b0;
        end
        2'b11: begin
          if (valid1) begin
            pop_data <= data1;
            data1    <= push_data;
          end else begin
            pop_data <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// Read-side FIFO controller: single-cycle reads, byte capture, framed valid/ready output.
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned FRAME_LEN = 16,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   fifo_empty,
  output logic                   fifo_rd_en,
  input  logic [DATA_W-1:0]      fifo_rd_data,
  fifo_drain_if.master           m,
  output logic [FRAME_CNT_W-1:0] frames_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [IDX_W-1:0] beat_idx;
  logic [1:0]       occupancy_c;
  logic             capture_c;
  logic             beat_last_c;
  logic             frame_end_c;
  logic [DATA_W:0]  head;

  // Next state plus capture-side strobes; IDLE re-checks the empty flag every time.
  always_comb begin
    next_state  = state;
    capture_c   = 1'b0;
    beat_last_c = (beat_idx == LAST_IDX);
    frame_end_c = m.m_valid && m.m_ready && m.m_last;
    case (state)
      IDLE: begin
        if (enable && !fifo_empty && (occupancy_c < 2'(BUF_DEPTH))) begin
          next_state = READ;
        end
      end
      READ:    next_state = CAPTURE;
      CAPTURE: begin
        capture_c  = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      fifo_rd_en  <= 1'b0;
      beat_idx    <= '0;
      frames_done <= '0;
    end else begin
      state      <= next_state;
      fifo_rd_en <= (next_state == READ);
      if (capture_c) begin
        beat_idx <= beat_last_c ? '0 : beat_idx + IDX_W'(1);
      end
      if (frame_end_c) begin
        frames_done <= frames_done + FRAME_CNT_W'(1);
      end
    end
  end

  drain_skid_buf #(
    .WIDTH (DATA_W + 1)
  ) u_buf (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (capture_c),
    .push_data   ({beat_last_c, fifo_rd_data}),
    .pop_valid   (m.m_valid),
    .pop_ready   (m.m_ready),
    .pop_data    (head),
    .occupancy_c (occupancy_c)
  );

  assign m.m_data = head[DATA_W-1:0];
  assign m.m_last = head[DATA_W];

endmodule

// File: tb/tb_fifo_drain.sv
// Bench for fifo_drain: FIFO model, stream scoreboard, directed tables and random traffic.
module tb_fifo_drain;

  localparam int FL = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- DUT 0: FRAME_LEN = 16 ----------------
  logic        enable = 1'b0;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  fifo_rd_data;
  logic [15:0] frames_done;
  fifo_drain_if #(.DATA_W(8)) s0 ();

  fifo_drain #(.DATA_W(8), .FRAME_LEN(FL), .BUF_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data), .m(s0), .frames_done(frames_done)
  );

  // ---------------- DUT 1: FRAME_LEN = 1 ----------------
  logic        en1 = 1'b1;
  logic        empty1;
  logic        rd_en1;
  logic [7:0]  rd_data1;
  logic [15:0] frames_done1;
  fifo_drain_if #(.DATA_W(8)) s1 ();

  fifo_drain #(.DATA_W(8), .FRAME_LEN(1), .BUF_DEPTH(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .enable(en1), .fifo_empty(empty1),
    .fifo_rd_en(rd_en1), .fifo_rd_data(rd_data1), .m(s1), .frames_done(frames_done1)
  );

  // Behavioural 16x8 FIFOs: read before write, registered empty flag lagging one cycle.
  logic       wr_en = 1'b0, wr1_en = 1'b0;
  logic [7:0] wr_data = '0, wr1_data = '0;
  logic [7:0] fq[$], hist[$], fq1[$], hist1[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fq.delete(); hist.delete(); fifo_empty <= 1'b1; fifo_rd_data <= '0;
      fq1.delete(); hist1.delete(); empty1 <= 1'b1; rd_data1 <= '0;
    end else begin
      fifo_empty <= (fq.size() == 0);
      empty1     <= (fq1.size() == 0);
      if (fifo_rd_en) begin
        chk("fifo0_underflow", 32'(fq.size() == 0), 32'd0);
        fifo_rd_data <= (fq.size() > 0) ? fq.pop_front() : 8'h00;
      end else fifo_rd_data <= '0;
      if (rd_en1) begin
        chk("fifo1_underflow", 32'(fq1.size() == 0), 32'd0);
        rd_data1 <= (fq1.size() > 0) ? fq1.pop_front() : 8'h00;
      end else rd_data1 <= '0;
      if (wr_en)  begin fq.push_back(wr_data);   hist.push_back(wr_data);   end
      if (wr1_en) begin fq1.push_back(wr1_data); hist1.push_back(wr1_data); end
    end
  end

  // Scoreboards: the k-th accepted beat is the k-th byte written; last when k mod FRAME_LEN hits the end.
  int          beat_k = 0, beat1_k = 0, rd_gap = 99, rd_cnt0 = 0, cyc = 0;
  logic [15:0] exp_frames = '0, exp_frames1 = '0;
  logic        prev_stall = 1'b0;
  logic [8:0]  prev_beat = '0;
  int          accept_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      beat_k = 0; beat1_k = 0; exp_frames = '0; exp_frames1 = '0;
      prev_stall = 1'b0; rd_gap = 99; rd_cnt0 = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(s0.m_valid), 32'd1);
        chk("hold_beat", 32'({s0.m_last, s0.m_data}), 32'(prev_beat));
      end
      if (fifo_rd_en) begin
        chk("rd_spacing", 32'(rd_gap >= 3), 32'd1);
        rd_gap = 0;
        rd_cnt0++;
      end
      rd_gap++;
      if (dut.capture_c) chk("buf_free_slot", 32'(dut.occupancy_c < 2'd2), 32'd1);
      if (s0.m_valid && s0.m_ready) begin
        if (beat_k < hist.size()) begin
          chk("beat_data", 32'(s0.m_data), 32'(hist[beat_k]));
          chk("beat_last", 32'(s0.m_last), 32'((beat_k % FL) == FL - 1));
        end else begin
          n_cmp++; n_bad++;
          $display("FAIL beat_extra: beat %0d accepted, only %0d written", beat_k, hist.size());
        end
        chk("frames_done", 32'(frames_done), 32'(exp_frames));
        if ((beat_k % FL) == FL - 1) exp_frames++;
        beat_k++;
        accept_cyc.push_back(cyc);
      end
      prev_stall = s0.m_valid && !s0.m_ready;
      prev_beat  = {s0.m_last, s0.m_data};

      if (s1.m_valid && s1.m_ready) begin
        if (beat1_k < hist1.size()) chk("f1_beat_data", 32'(s1.m_data), 32'(hist1[beat1_k]));
        chk("f1_beat_last", 32'(s1.m_last), 32'd1);
        chk("f1_frames_done", 32'(frames_done1), 32'(exp_frames1));
        exp_frames1++;
        beat1_k++;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr0(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; step(); wr_en = 1'b0;
  endtask

  task automatic wr1(input logic [7:0] d);
    wr1_en = 1'b1; wr1_data = d; step(); wr1_en = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; wr_en = 1'b0; wr1_en = 1'b0;
    step(); step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic drain0(input int budget);
    for (int t = 0; t < budget && beat_k < hist.size(); t++) step();
    chk("drain0_complete", 32'(beat_k), 32'(hist.size()));
  endtask

  task automatic drain1(input int budget);
    for (int t = 0; t < budget && beat1_k < hist1.size(); t++) step();
    chk("drain1_complete", 32'(beat1_k), 32'(hist1.size()));
  endtask

  typedef struct {
    int         nbytes;
    logic       en;
    int         exp_reads;
    logic       exp_valid;
    logic [7:0] exp_head;
  } vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t vt[5];
    logic [5:0] rdv, vv;
    int t, bad_gap;

    s0.m_ready = 1'b0;
    s1.m_ready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(s0.m_valid), 32'd0);
    chk("rst_data", 32'(s0.m_data), 32'd0);
    chk("rst_last", 32'(s0.m_last), 32'd0);
    chk("rst_frames", 32'(frames_done), 32'd0);

    // Single byte: read pulse one cycle after IDLE sees non-empty, beat three cycles after.
    enable = 1'b1; s0.m_ready = 1'b1;
    wr0(8'hA5);
    t = 0;
    @(negedge clk);
    while (fifo_empty && t < 10) begin @(negedge clk); t++; end
    chk("t1_nonempty_seen", 32'(fifo_empty), 32'd0);
    for (int c = 0; c < 6; c++) begin
      rdv[c] = fifo_rd_en;
      vv[c]  = s0.m_valid;
      if (c == 3) begin
        chk("t1_data", 32'(s0.m_data), 32'hA5);
        chk("t1_last", 32'(s0.m_last), 32'd0);
      end
      @(negedge clk);
    end
    chk("t1_rd_pattern", 32'(rdv), 32'b000010);
    chk("t1_valid_pattern", 32'(vv), 32'b001000);
    step();
    drain0(20);

    // Full frame: 16 beats every 3 cycles, last only on 0x0F.
    do_reset();
    accept_cyc.delete();
    for (int i = 0; i < 16; i++) wr0(8'(i));
    drain0(100);
    chk("t2_frames", 32'(frames_done), 32'd1);
    bad_gap = 0;
    for (int i = 1; i < accept_cyc.size(); i++)
      if (accept_cyc[i] - accept_cyc[i-1] != 3) bad_gap++;
    chk("t2_beat_count", 32'(accept_cyc.size()), 32'd16);
    chk("t2_spacing", 32'(bad_gap), 32'd0);

    // Backpressure table: reads issued during a 20-cycle stall and the held head beat.
    vt[0] = '{nbytes: 5,  en: 1'b1, exp_reads: 2, exp_valid: 1'b1, exp_head: 8'h30};
    vt[1] = '{nbytes: 1,  en: 1'b1, exp_reads: 1, exp_valid: 1'b1, exp_head: 8'h30};
    vt[2] = '{nbytes: 0,  en: 1'b1, exp_reads: 0, exp_valid: 1'b0, exp_head: 8'h00};
    vt[3] = '{nbytes: 3,  en: 1'b0, exp_reads: 0, exp_valid: 1'b0, exp_head: 8'h00};
    vt[4] = '{nbytes: 16, en: 1'b1, exp_reads: 2, exp_valid: 1'b1, exp_head: 8'h30};
    for (int v = 0; v < 5; v++) begin
      do_reset();
      enable = vt[v].en; s0.m_ready = 1'b0;
      for (int i = 0; i < vt[v].nbytes; i++) wr0(8'h30 + 8'(i));
      for (int i = 0; i < 20; i++) step();
      chk($sformatf("t3_v%0d_reads", v), 32'(rd_cnt0), 32'(vt[v].exp_reads));
      chk($sformatf("t3_v%0d_valid", v), 32'(s0.m_valid), 32'(vt[v].exp_valid));
      chk($sformatf("t3_v%0d_head", v), 32'(s0.m_data), 32'(vt[v].exp_head));
      enable = 1'b1; s0.m_ready = 1'b1;
      drain0(150);
    end

    // Enable toggle after the third capture; frame continues on re-enable.
    do_reset();
    enable = 1'b0; s0.m_ready = 1'b1;
    for (int i = 0; i < 16; i++) wr0(8'h40 + 8'(i));
    enable = 1'b1;
    t = 0;
    while (rd_cnt0 < 3 && t < 50) begin step(); t++; end
    step();
    enable = 1'b0;
    for (int i = 0; i < 15; i++) step();
    chk("t4_reads_while_off", 32'(rd_cnt0), 32'd3);
    chk("t4_drained_while_off", 32'(beat_k), 32'd3);
    chk("t4_valid_while_off", 32'(s0.m_valid), 32'd0);
    enable = 1'b1;
    drain0(100);
    chk("t4_frames", 32'(frames_done), 32'd1);

    // Reset in the READ cycle clears everything at once.
    wr0(8'h77); wr0(8'h78);
    t = 0;
    @(negedge clk);
    while (!fifo_rd_en && t < 20) begin @(negedge clk); t++; end
    chk("t5_in_read", 32'(fifo_rd_en), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t5_valid", 32'(s0.m_valid), 32'd0);
    chk("t5_data", 32'(s0.m_data), 32'd0);
    chk("t5_last", 32'(s0.m_last), 32'd0);
    chk("t5_frames", 32'(frames_done), 32'd0);
    step(); step();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) step();
    chk("t5_no_read_after", 32'(rd_cnt0), 32'd0);
    chk("t5_no_valid_after", 32'(s0.m_valid), 32'd0);

    // FRAME_LEN = 1: every beat is last; counter wraps past 0xFFFF.
    for (int i = 0; i < 3; i++) wr1(8'h90 + 8'(i));
    drain1(50);
    chk("t6_frames", 32'(frames_done1), 32'd3);
    force dut1.frames_done = 16'hFFFE;
    exp_frames1 = 16'hFFFE;
    step();
    release dut1.frames_done;
    for (int i = 0; i < 3; i++) wr1(8'hA0 + 8'(i));
    drain1(50);
    chk("t6_wrap", 32'(frames_done1), 32'd1);

    // Random traffic against the scoreboard.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 1) == 1 && fq.size() < 14) begin
        wr_en = 1'b1; wr_data = 8'($urandom);
      end else wr_en = 1'b0;
      s0.m_ready = ($urandom_range(0, 9) < 6);
      enable     = ($urandom_range(0, 19) != 0);
      step();
    end
    wr_en = 1'b0; enable = 1'b1; s0.m_ready = 1'b1;
    drain0(300);
    chk("rand_frames", 32'(frames_done), 32'(exp_frames));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side controller for the 16×8 FIFO. Issues single-cycle reads when the FIFO reports non-empty, captures the returned byte, and presents it on a valid/ready byte stream. Frames are marked with `m_last` every FRAME_LEN beats. Sits between the FIFO and any downstream byte consumer (serializer, packetizer) that can apply backpressure.

## Interface

**Parameters**
- `DATA_W`, 8: byte width; must equal the FIFO data width.
- `FRAME_LEN`, 16: beats per frame, legal range 1..256.
- `BUF_DEPTH`, 2: output buffer entries, fixed at 2.

**Ports**
- `clk`  in  1: single clock; all logic is rising-edge.
- `reset_n`  in  1: asynchronous, active-low reset. Same reset net as the FIFO, inverted at the FIFO.
- `enable`  in  1: permits new reads; an in-flight read always completes.
- `fifo_empty`  in  1: FIFO underflow/empty flag (registered, lags pointer by one cycle).
- `fifo_rd_en`  out  1: FIFO read enable; one-cycle pulse.
- `fifo_rd_data`  in  DATA_W: FIFO data_out; valid in the cycle after `fifo_rd_en`.
- `m_valid`  out  1: stream beat valid.
- `m_ready`  in  1: downstream accepts.
- `m_data`  out  DATA_W: beat data.
- `m_last`  out  1: final beat of frame.
- `frames_done`  out  16: count of frames whose last beat was accepted; wraps 0xFFFF→0.

## Operation

**FSM states:** IDLE, READ, CAPTURE.
- **IDLE → READ** when `enable`=1, `fifo_empty`=0, and buffer occupancy < BUF_DEPTH, all sampled at the same edge. Otherwise stay in IDLE.
- **READ:** `fifo_rd_en`=1 (registered, `state==READ`). Always → CAPTURE.
- **CAPTURE:** write `fifo_rd_data` and the current `m_last` flag into the buffer. Always → IDLE.
- Never chain CAPTURE → READ. `fifo_empty` is stale during CAPTURE, so IDLE re-evaluates it.

**Output buffer:**
- 2-entry FIFO. `m_valid` = occupancy ≠ 0. `m_data` and `m_last` come from the head entry.
- Pop on `m_valid && m_ready`. Push and pop in the same cycle keep occupancy unchanged.
- A push into a full buffer is impossible by construction (free slot checked in IDLE; only pops occur in between). Bench asserts this.

**Beat index:**
- 8-bit, advanced at capture. Stored `m_last` = (index == FRAME_LEN-1).
- Index wraps to 0 after FRAME_LEN-1. When FRAME_LEN=1, every beat is last.

**frames_done:** +1 on each accepted beat with `m_last`=1.

**enable:** deasserting stops new reads. Buffered beats still drain. Index and frame count are retained, and reads resume mid-frame when `enable` returns.

## Timing

- **Reset values:** `fifo_rd_en`=0, `m_valid`=0, `m_data`=0, `m_last`=0, `frames_done`=0, state IDLE, index 0, buffer empty.
- **Latency:** conditions true in cycle n → `fifo_rd_en` high in n+1 → capture at end of n+2 → `m_valid` high in n+3.
- **Throughput:** at most 1 byte per 3 cycles.
- **Backpressure:** with `m_ready`=0, at most 2 beats are buffered and then reads stop. No beat is ever lost or duplicated.
- **Stability:** `m_data`/`m_last` are stable while `m_valid`=1 and `m_ready`=0.
- **Reset mid-operation:** immediate clear of all state. An in-flight read is discarded; the FIFO is reset simultaneously.
- **`fifo_rd_data` outside CAPTURE:** ignored (the FIFO drives 0 when not reading).

## Structure

**Package `fifo_drain_pkg`:**
- State encoding localparams: IDLE=2'd0, READ=2'd1, CAPTURE=2'd2.
- Default `DATA_W`.
- `FRAME_CNT_W`=16.

**Sub-module `drain_skid_buf`:**
- 2-entry, (DATA_W+1)-bit, valid/ready buffer.
- Ports: push, push_data, pop-side valid/ready/data, occupancy.
- Top level holds the FSM, beat index, and frames_done.

## Test plan

- **Single byte:** FIFO holds 0xA5, `m_ready`=1 → `fifo_rd_en` one pulse, `m_valid` high 3 cycles after IDLE sees non-empty, `m_data`=0xA5, `m_last`=0.
- **Full frame:** write 16 bytes 0x00..0x0F, FRAME_LEN=16, `m_ready`=1 → beats in order, spaced 3 cycles, `m_last` only on 0x0F, `frames_done`=1.
- **Backpressure:** 5 bytes queued, `m_ready`=0 for 20 cycles → exactly 2 reads issued, `m_data` held at first byte. Then `m_ready`=1 → remaining 3 delivered in order, no loss.
- **enable toggle:** `enable`=0 after 3rd capture → no further `fifo_rd_en`, buffered beats drain. Re-enable → 4th beat has index 3 and frame continues.
- **Reset mid-read:** assert `reset_n`=0 in READ cycle → all outputs 0 immediately, `frames_done`=0. After release with FIFO empty, `fifo_rd_en` stays 0.
- **FRAME_LEN=1 wrap:** 3 bytes accepted → `m_last`=1 on each, `frames_done`=3. Preload `frames_done` near 0xFFFF (force) → wraps to 0.
